// File: rtl/joy_scan_pkg.sv
// Shared definitions for the two-player joystick scanner: bit indices, scan states,
// and the opposing-direction cleanup applied to debounced samples.
package joy_scan_pkg;

   localparam int unsigned JOY_UP    = 0;
   localparam int unsigned JOY_DOWN  = 1;
   localparam int unsigned JOY_LEFT  = 2;
   localparam int unsigned JOY_RIGHT = 3;
   localparam int unsigned JOY_FIRE1 = 4;
   localparam int unsigned JOY_FIRE2 = 5;
   localparam int unsigned JOY_W     = 6;

   typedef enum logic [1:0] {
      IDLE,
      SEL1,
      SEL2,
      UPD
   } scan_state_t;

   // Opposing directions pressed together cancel out; fire buttons pass untouched.
   function automatic logic [JOY_W-1:0] clean(input logic [JOY_W-1:0] raw);
      logic [JOY_W-1:0] res;
      res = raw;
      if (raw[JOY_UP] && raw[JOY_DOWN]) begin
         res[JOY_UP]   = 1'b0;
         res[JOY_DOWN] = 1'b0;
      end
      if (raw[JOY_LEFT] && raw[JOY_RIGHT]) begin
         res[JOY_LEFT]  = 1'b0;
         res[JOY_RIGHT] = 1'b0;
      end
      return res;
   endfunction

endpackage

// File: rtl/joy_scan_if.sv
// Joystick port bundle between the board pins, the scanner and the pong core.
interface joy_scan_if;
   logic       ce;
   logic       vsync;
   logic [5:0] joy_n;
   logic       joy_sel;
   logic [7:0] joy1;
   logic [7:0] joy2;
   logic       strobe;

   modport master (
      output ce, vsync, joy_n,
      input  joy_sel, joy1, joy2, strobe
   );

   modport slave (
      input  ce, vsync, joy_n,
      output joy_sel, joy1, joy2, strobe
   );
endinterface

// File: rtl/joy_scan_debounce.sv
// Per-player frame debouncer: an output update needs STABLE identical consecutive samples.
module joy_debounce
   import joy_scan_pkg::*;
#(
   parameter int unsigned STABLE = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic [JOY_W-1:0] raw,
   output logic [7:0]       joy
);

   localparam int unsigned CW = (STABLE > 1) ? $clog2(STABLE) : 1;
   localparam logic [CW-1:0] CMAX = CW'(STABLE - 1);

   logic [JOY_W-1:0] cand;
   logic [CW-1:0]    cnt;
   logic [CW-1:0]    cnt_nxt;

   // cnt is the number of repeats of cand beyond its first sighting, saturating at STABLE-1.
   always_comb begin
      cnt_nxt = cnt;
      if (raw != cand) begin
         cnt_nxt = '0;
      end else if (cnt != CMAX) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cand <= '0;
         cnt  <= '0;
         joy  <= '0;
      end else if (en) begin
         cand <= raw;
         cnt  <= cnt_nxt;
         if (cnt_nxt == CMAX) begin
            joy <= {2'b00, clean(raw)};
         end
      end
   end

endmodule

// File: rtl/joy_scan.sv
// Two-player joystick scanner: per frame, selects each player on the shared port,
// waits for the mux to settle, samples, then debounces both players.
module joy_scan
   import joy_scan_pkg::*;
#(
   parameter int unsigned SETTLE = 4,
   parameter int unsigned STABLE = 2
) (
   input  logic       clock,
   input  logic       reset,
   joy_scan_if.slave  bus
);

   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CSTART = CW'(SETTLE - 1);

   scan_state_t      state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic             sel, sel_nxt;
   logic             pending, pending_nxt;
   logic [JOY_W-1:0] raw1, raw1_nxt;
   logic [JOY_W-1:0] raw2, raw2_nxt;
   logic [JOY_W-1:0] joy_meta, joy_sync;
   logic             vsync_q;
   logic             vs_edge;
   logic             upd;

   assign vs_edge     = bus.vsync & ~vsync_q;
   assign bus.joy_sel = sel;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         sel      <= 1'b0;
         pending  <= 1'b0;
         raw1     <= '0;
         raw2     <= '0;
         joy_meta <= '1;
         joy_sync <= '1;
         vsync_q  <= 1'b0;
         bus.strobe <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         sel      <= sel_nxt;
         pending  <= pending_nxt;
         raw1     <= raw1_nxt;
         raw2     <= raw2_nxt;
         joy_meta <= bus.joy_n;
         joy_sync <= joy_meta;
         vsync_q  <= bus.vsync;
         bus.strobe <= upd;
      end
   end

   // Edge capture is not gated by ce; consuming pending in IDLE overrides a same-clock edge.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      sel_nxt     = sel;
      pending_nxt = pending;
      raw1_nxt    = raw1;
      raw2_nxt    = raw2;
      upd         = 1'b0;
      if (state == IDLE && vs_edge) begin
         pending_nxt = 1'b1;
      end
      if (bus.ce) begin
         case (state)
            IDLE: begin
               if (pending) begin
                  sel_nxt     = 1'b0;
                  cnt_nxt     = CSTART;
                  pending_nxt = 1'b0;
                  state_nxt   = SEL1;
               end
            end
            SEL1: begin
               if (cnt != '0) begin
                  cnt_nxt = cnt - 1'b1;
               end else begin
                  raw1_nxt  = ~joy_sync;
                  sel_nxt   = 1'b1;
                  cnt_nxt   = CSTART;
                  state_nxt = SEL2;
               end
            end
            SEL2: begin
               if (cnt != '0) begin
                  cnt_nxt = cnt - 1'b1;
               end else begin
                  raw2_nxt  = ~joy_sync;
                  sel_nxt   = 1'b0;
                  state_nxt = UPD;
               end
            end
            UPD: begin
               upd       = 1'b1;
               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   joy_debounce #(.STABLE(STABLE)) u_deb1 (
      .clock (clock),
      .reset (reset),
      .en    (upd),
      .raw   (raw1),
      .joy   (bus.joy1)
   );

   joy_debounce #(.STABLE(STABLE)) u_deb2 (
      .clock (clock),
      .reset (reset),
      .en    (upd),
      .raw   (raw2),
      .joy   (bus.joy2)
   );

endmodule
